// File: rtl/e203_itcm_ram_arbt.sv
// ITCM SRAM front-end: arbitrates IFU/LSU onto one SRAM port, holds stalled read data, drives light-sleep.
// Optional E203_ITCM_ARBT_RR_EN selects round-robin instead of fixed LSU-over-IFU priority.
module e203_itcm_ram_arbt #(
    parameter int AW      = 13,
    parameter int DW      = 64,
    parameter int MW      = 8,
    parameter int LS_IDLE = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_cmd_valid,
    output logic          ifu_cmd_ready,
    input  logic [AW-1:0] ifu_cmd_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_rdata,
    input  logic          lsu_cmd_valid,
    output logic          lsu_cmd_ready,
    input  logic          lsu_cmd_read,
    input  logic [AW-1:0] lsu_cmd_addr,
    input  logic [DW-1:0] lsu_cmd_wdata,
    input  logic [MW-1:0] lsu_cmd_wmask,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rsp_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_sd,
    output logic          ram_ds,
    output logic          ram_ls
);
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam int   CW      = (LS_IDLE < 1) ? 1 : $clog2(LS_IDLE + 1);

    logic          r_pending;
    logic          r_owner;
    logic          r_is_read;
    logic          r_held;
    logic [DW-1:0] r_hold;
    logic [CW-1:0] r_idle_cnt;

    logic          w_pend;
    logic          w_rsp_hs;
    logic          w_can_issue;
    logic          w_pri_lsu;
    logic          w_gnt_lsu;
    logic          w_gnt_ifu;
    logic          w_issue;
    logic          w_wr;
    logic [DW-1:0] w_rdata;

`ifdef E203_ITCM_ARBT_RR_EN
    logic r_last;
    assign w_pri_lsu = (r_last == OWN_IFU);
`else
    assign w_pri_lsu = 1'b1;
`endif

    // Outputs are forced quiet during the synchronous reset cycle itself.
    assign w_pend      = r_pending & ~rst;
    assign w_rsp_hs    = w_pend & ((r_owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready);
    assign w_can_issue = ~rst & (~r_pending | w_rsp_hs);
    assign w_gnt_lsu   = w_can_issue & lsu_cmd_valid & (~ifu_cmd_valid | w_pri_lsu);
    assign w_gnt_ifu   = w_can_issue & ifu_cmd_valid & ~w_gnt_lsu;
    assign w_issue     = w_gnt_lsu | w_gnt_ifu;
    assign w_wr        = w_gnt_lsu & ~lsu_cmd_read;

    assign ifu_cmd_ready = w_gnt_ifu;
    assign lsu_cmd_ready = w_gnt_lsu;

    assign ram_cs   = w_issue;
    assign ram_we   = w_wr;
    assign ram_addr = w_gnt_lsu ? lsu_cmd_addr : (w_gnt_ifu ? ifu_cmd_addr : '0);
    assign ram_wem  = w_wr ? lsu_cmd_wmask : '0;
    assign ram_din  = w_wr ? lsu_cmd_wdata : '0;
    assign ram_sd   = 1'b0;
    assign ram_ds   = 1'b0;

    // Bypass SRAM output on the first response cycle, then serve the hold copy.
    assign w_rdata = ~r_is_read ? '0 : (r_held ? r_hold : ram_dout);

    assign ifu_rsp_valid = w_pend & (r_owner == OWN_IFU);
    assign lsu_rsp_valid = w_pend & (r_owner == OWN_LSU);
    assign ifu_rsp_rdata = ifu_rsp_valid ? w_rdata : '0;
    assign lsu_rsp_rdata = lsu_rsp_valid ? w_rdata : '0;

    assign ram_ls = (LS_IDLE != 0) & ~rst & ~r_pending & ~ifu_cmd_valid & ~lsu_cmd_valid
                  & (r_idle_cnt >= CW'(LS_IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= 1'b0;
            r_owner    <= OWN_IFU;
            r_is_read  <= 1'b0;
            r_held     <= 1'b0;
            r_hold     <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_pending <= 1'b1;
                r_owner   <= w_gnt_lsu ? OWN_LSU : OWN_IFU;
                r_is_read <= w_gnt_ifu | lsu_cmd_read;
            end else if (w_rsp_hs) begin
                r_pending <= 1'b0;
            end

            if (w_rsp_hs) begin
                r_held <= 1'b0;
            end else if (r_pending && !r_held) begin
                r_held <= 1'b1;
                r_hold <= ram_dout;
            end

            if (ifu_cmd_valid || lsu_cmd_valid || r_pending)
                r_idle_cnt <= '0;
            else if (r_idle_cnt < CW'(LS_IDLE))
                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

`ifdef E203_ITCM_ARBT_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_last <= OWN_IFU;
        else if (w_issue)
            r_last <= w_gnt_lsu ? OWN_LSU : OWN_IFU;
    end
`endif

endmodule

// File: tb/tb_e203_itcm_ram_arbt.sv
// Bench for e203_itcm_ram_arbt: directed scenarios plus random traffic against a transaction-level model.
module tb_e203_itcm_ram_arbt;
    localparam int AW = 13;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int LS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_cmd_valid = 1'b0, ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_ready = 1'b1;
    logic [AW-1:0] ifu_cmd_addr = '0;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          lsu_cmd_valid = 1'b0, lsu_cmd_ready, lsu_cmd_read = 1'b1;
    logic [AW-1:0] lsu_cmd_addr = '0;
    logic [DW-1:0] lsu_cmd_wdata = '0;
    logic [MW-1:0] lsu_cmd_wmask = '0;
    logic          lsu_rsp_valid, lsu_rsp_ready = 1'b1;
    logic [DW-1:0] lsu_rsp_rdata;
    logic          ram_cs, ram_we, ram_sd, ram_ds, ram_ls;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    int n_cmp = 0;
    int n_err = 0;

    e203_itcm_ram_arbt #(.AW(AW), .DW(DW), .MW(MW), .LS_IDLE(LS)) dut (
        .clk(clk), .rst(rst),
        .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_addr(ifu_cmd_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
        .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_val(input int i);
        logic [31:0] a, b;
        a = i * 32'h9E3779B9;
        b = ~i * 32'h85EBCA6B;
        if (i == 16) return 64'hDEADBEEF_00000001;
        if (i == 4)  return 64'hAAAAAAAA_BBBBBBBB;
        return {a, b};
    endfunction

    // SRAM environment: 1-cycle read latency, junk on dout whenever no read was issued.
    logic [63:0] emem [0:(1<<AW)-1];
    logic        e_init = 1'b0;
    always @(posedge clk) begin
        if (!e_init) begin
            for (int i = 0; i < (1<<AW); i++) emem[i] <= init_val(i);
            e_init <= 1'b1;
        end else if (ram_cs && ram_we) begin
            for (int b = 0; b < MW; b++)
                if (ram_wem[b]) emem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
        if (ram_cs && !ram_we) ram_dout <= emem[ram_addr];
        else                   ram_dout <= {$urandom, $urandom};
    end

    // Transaction-level reference: one outstanding transaction plus a reference memory.
    logic [63:0] rmem [0:(1<<AW)-1];
    logic        m_init = 1'b0;
    logic        m_vld = 1'b0, m_own = 1'b0, m_last = 1'b0;
    logic [63:0] m_data = '0;
    int          m_idle = 0;
    logic        c_hs, c_can, c_pl, c_gl, c_gi, c_ls;
    logic        e_hs = 1'b0, e_gl = 1'b0, e_gi = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ifu_rv", ifu_rsp_valid, 0);
            chk("rst_lsu_rv", lsu_rsp_valid, 0);
            chk("rst_ifu_rdy", ifu_cmd_ready, 0);
            chk("rst_lsu_rdy", lsu_cmd_ready, 0);
            chk("rst_cs", ram_cs, 0);
            chk("rst_ls", ram_ls, 0);
            e_hs <= 1'b0; e_gl <= 1'b0; e_gi <= 1'b0;
        end else begin
            c_hs  = m_vld && (m_own ? lsu_rsp_ready : ifu_rsp_ready);
            c_can = !m_vld || c_hs;
`ifdef E203_ITCM_ARBT_RR_EN
            c_pl  = (m_last == 1'b0);
`else
            c_pl  = 1'b1;
`endif
            c_gl  = c_can && lsu_cmd_valid && (!ifu_cmd_valid || c_pl);
            c_gi  = c_can && ifu_cmd_valid && !c_gl;
            c_ls  = (m_idle >= LS) && !ifu_cmd_valid && !lsu_cmd_valid && !m_vld;
            chk("ifu_rv", ifu_rsp_valid, m_vld && !m_own);
            chk("lsu_rv", lsu_rsp_valid, m_vld && m_own);
            if (m_vld && m_own)  chk("lsu_rdata", lsu_rsp_rdata, m_data);
            if (m_vld && !m_own) chk("ifu_rdata", ifu_rsp_rdata, m_data);
            chk("lsu_rdy", lsu_cmd_ready, c_gl);
            chk("ifu_rdy", ifu_cmd_ready, c_gi);
            chk("cs", ram_cs, c_gl || c_gi);
            if (c_gl || c_gi) begin
                chk("addr", ram_addr, c_gl ? lsu_cmd_addr : ifu_cmd_addr);
                chk("we", ram_we, c_gl && !lsu_cmd_read);
                chk("wem", ram_wem, (c_gl && !lsu_cmd_read) ? lsu_cmd_wmask : 8'h00);
                if (c_gl && !lsu_cmd_read) chk("din", ram_din, lsu_cmd_wdata);
            end
            chk("ls", ram_ls, c_ls);
            chk("sd_ds", {ram_sd, ram_ds}, 0);
            e_hs <= c_hs; e_gl <= c_gl; e_gi <= c_gi;
        end
    end

    always @(posedge clk) begin
        if (!m_init) begin
            for (int i = 0; i < (1<<AW); i++) rmem[i] <= init_val(i);
            m_init <= 1'b1;
        end
        if (rst) begin
            m_vld <= 1'b0; m_last <= 1'b0; m_idle <= 0;
        end else begin
            if (e_gl) begin
                m_vld <= 1'b1; m_own <= 1'b1; m_last <= 1'b1;
                if (lsu_cmd_read) m_data <= rmem[lsu_cmd_addr];
                else begin
                    m_data <= '0;
                    for (int b = 0; b < MW; b++)
                        if (lsu_cmd_wmask[b]) rmem[lsu_cmd_addr][b*8 +: 8] <= lsu_cmd_wdata[b*8 +: 8];
                end
            end else if (e_gi) begin
                m_vld <= 1'b1; m_own <= 1'b0; m_last <= 1'b0;
                m_data <= rmem[ifu_cmd_addr];
            end else if (e_hs) begin
                m_vld <= 1'b0;
            end
            if (ifu_cmd_valid || lsu_cmd_valid || m_vld) m_idle <= 0;
            else if (m_idle < LS)                        m_idle <= m_idle + 1;
        end
    end

    task automatic drv(input logic iv, input logic [AW-1:0] ia, input logic lv, input logic lr,
                       input logic [AW-1:0] la, input logic [63:0] wd, input logic [7:0] wm,
                       input logic irr, input logic lrr);
        ifu_cmd_valid = iv; ifu_cmd_addr = ia;
        lsu_cmd_valid = lv; lsu_cmd_read = lr; lsu_cmd_addr = la;
        lsu_cmd_wdata = wd; lsu_cmd_wmask = wm;
        ifu_rsp_ready = irr; lsu_rsp_ready = lrr;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drv(0, 0, 0, 1, 0, 0, 0, 1, 1);
            step();
        end
    endtask

    logic [7:0]  pat;
    logic [7:0]  exp_pat;
    logic [63:0] cap;

    initial begin
        step(); step(); step();
        rst = 1'b0;

        // Both requesters valid every cycle straight out of reset.
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            drv(1, 13'h2, 1, 1, 13'h1, 0, 0, 1, 1);
            @(negedge clk);
            pat[i] = lsu_cmd_ready;
            step();
        end
`ifdef E203_ITCM_ARBT_RR_EN
        exp_pat = 8'h55;
`else
        exp_pat = 8'hFF;
`endif
        chk("arb_pattern", pat, exp_pat);
        idle(1);

        // IFU read with back-to-back follow-up.
        drv(1, 13'h10, 0, 1, 0, 0, 0, 1, 1);
        step();
        @(negedge clk);
        chk("ifu_data", ifu_rsp_rdata, 64'hDEADBEEF_00000001);
        chk("ifu_b2b_rdy", ifu_cmd_ready, 1);
        step();
        idle(1);

        // Partial write then read-back.
        drv(0, 0, 1, 0, 13'h4, 64'h11223344_55667788, 8'h0F, 1, 1);
        step();
        drv(0, 0, 1, 1, 13'h4, 0, 0, 1, 1);
        @(negedge clk);
        chk("wr_rdata0", lsu_rsp_rdata, 0);
        step();
        drv(0, 0, 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("rd_merge", lsu_rsp_rdata, 64'hAAAAAAAA_55667788);
        step();

        // LSU read stalled five cycles while IFU keeps asking.
        drv(0, 0, 1, 1, 13'h4, 0, 0, 1, 0);
        step();
        cap = '0;
        for (int i = 0; i < 5; i++) begin
            drv(1, 13'h3, 0, 1, 0, 0, 0, 1, 0);
            @(negedge clk);
            if (i == 0) cap = lsu_rsp_rdata;
            chk("stall_hold", lsu_rsp_rdata, 64'hAAAAAAAA_55667788);
            chk("stall_nocs", ram_cs, 0);
            step();
        end
        chk("stall_cap", cap, 64'hAAAAAAAA_55667788);
        drv(1, 13'h3, 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("stall_hs", lsu_rsp_valid && lsu_rsp_ready, 1);
        chk("stall_hs_cs", ram_cs, 1);
        step();
        idle(1);

        // Light-sleep entry and same-cycle wakeup.
        idle(19);
        drv(0, 0, 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("ls_on", ram_ls, 1);
        step();
        drv(1, 13'h7, 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("ls_drop", ram_ls, 0);
        chk("ls_cs", ram_cs, 1);
        step();
        idle(1);

        // Reset while an LSU response is stalled.
        drv(0, 0, 1, 1, 13'h10, 0, 0, 1, 0);
        step();
        drv(0, 0, 0, 1, 0, 0, 0, 1, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_drop", lsu_rsp_valid, 0);
        step();
        drv(0, 0, 1, 1, 13'h10, 0, 0, 1, 1);
        step();
        drv(0, 0, 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("post_rst_rd", lsu_rsp_rdata, 64'hDEADBEEF_00000001);
        step();

        // Random traffic; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            drv(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                {$urandom, $urandom}, 8'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            if ((i % 500) == 499) idle(LS + 2);
            else step();
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
